multicycle_control_fsm: RTL and testbench

Parametrised multi-cycle RV32I main control unit: a Moore FSM that sequences fetch, decode, execute, memory and write-back for every RV32I base opcode class. It drives the multi-cycle datapath strobes (PC, IR, register file, ALU muxes, memory) and supports variable-latency memory via a fixed-latency counter or a `memReady` handshake. It sits between the instruction register's opcode field and the shared datapath, replacing the earlier 12-state control skeleton.

---
 rtl/control_pkg.sv | 64 ++++++
 rtl/mem_wait_counter.sv | 46 ++++
 rtl/multicycle_control_fsm.sv | 230 +++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// -----------------------------------------------------------------------------
// control_pkg
// Shared definitions for the multi-cycle RV32I main control unit:
//   - state_t      : the sixteen control states (encoding is the debug `state` bus)
//   - OPC_*        : RV32I base opcode classes, instruction bits [6:0]
//   - SRCA_*/SRCB_*: ALU operand mux encodings
//   - ALUOP_*      : ALU control class handed to the ALU decoder
//   - PCSRC_*      : PC next-value mux encodings
//   - WBSEL_*      : register-file write-data mux encodings
// -----------------------------------------------------------------------------
package control_pkg;

    typedef enum logic [3:0] {
        RESET     = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        EXEC_R    = 4'd3,
        EXEC_I    = 4'd4,
        LUI       = 4'd5,
        ALU_WB    = 4'd6,
        BRANCH    = 4'd7,
        JAL       = 4'd8,
        JALR      = 4'd9,
        MEM_ADDR  = 4'd10,
        LOAD_MEM  = 4'd11,
        LOAD_WB   = 4'd12,
        STORE_MEM = 4'd13,
        TRAP      = 4'd14,
        HALT      = 4'd15
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_REGA  = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_REGB  = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;

    localparam logic [1:0] ALUOP_ADD    = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT  = 2'd2;

    localparam logic [1:0] PCSRC_ALU      = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT   = 2'd1;
    localparam logic [1:0] PCSRC_ALU_LSB0 = 2'd2;

    localparam logic [1:0] WBSEL_ALUOUT = 2'd0;
    localparam logic [1:0] WBSEL_MDR    = 2'd1;
    localparam logic [1:0] WBSEL_PC     = 2'd2;

endpackage

// File: rtl/mem_wait_counter.sv
// -----------------------------------------------------------------------------
// mem_wait_counter
// Decides when the current memory access (instruction fetch, load or store)
// completes. Either a fixed latency of MEM_LATENCY cycles, counted while the
// FSM sits in a memory state, or the external memReady handshake.
//
// Parameters:
//   MEM_LATENCY   : cycles per access in fixed-latency mode (1..15)
//   USE_MEM_READY : 1 = complete on memReady, 0 = complete after MEM_LATENCY
// Ports:
//   clk, rstN  : clock (rising edge), asynchronous active-low reset
//   inMemState : FSM is in FETCH, LOAD_MEM or STORE_MEM this cycle
//   memReady   : external completion strobe (handshake mode only)
//   memDone    : the access finishes at the end of this cycle
// -----------------------------------------------------------------------------
module mem_wait_counter #(
    parameter int MEM_LATENCY   = 1,
    parameter bit USE_MEM_READY = 1'b0
) (
    input  logic clk,
    input  logic rstN,
    input  logic inMemState,
    input  logic memReady,
    output logic memDone
);

    logic [3:0] count;

    // Parameter-constant select: the unused branch folds away in synthesis.
    assign memDone = USE_MEM_READY ? memReady
                                   : (count == 4'(MEM_LATENCY - 1));

    // NOTE: state is updated with non-blocking assignments under an async
    // reset, so every flop sees the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= 4'd0;
        end else if (!inMemState || memDone) begin
            // Start every access from zero, including back-to-back ones.
            count <= 4'd0;
        end else begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
// Moore main control FSM for a multi-cycle RV32I datapath. Sequences fetch,
// decode, execute, memory and write-back for every base opcode class and
// drives the datapath strobes and mux selects from the current state. The
// only input-dependent outputs are irWrite/pcWrite in FETCH, which fire in
// the cycle the instruction fetch completes.
//
// Build option:
//   MULTICYCLE_CONTROL_SYSTEM_EN : when defined, SYSTEM (ECALL/EBREAK) enters
//   HALT and raises `halted`; otherwise SYSTEM traps and `halted` stays 0.
//
// Parameters: MEM_LATENCY (1..15), USE_MEM_READY (see mem_wait_counter).
// Ports:
//   clk, rstN          : clock (rising edge), asynchronous active-low reset
//   opcode             : instruction bits [6:0], used in DECODE and MEM_ADDR
//   memReady           : memory completion strobe (handshake mode)
//   pcWrite, pcWriteCond, irWrite, regWrite, memRead, memWrite : strobes
//   memGetData         : memory address select, 0 = PC, 1 = ALUOut
//   regWriteDataSelect : 0 = ALUOut, 1 = MDR, 2 = PC (link)
//   aluSrcA            : 0 = PC, 1 = regA, 2 = oldPC, 3 = zero
//   aluSrcB            : 0 = regB, 1 = 4, 2 = immediate
//   aluOp              : 0 = add, 1 = branch compare, 2 = funct decode
//   pcSrc              : 0 = ALU result, 1 = ALUOut, 2 = ALU result & ~1
//   illegal, halted    : sticky status (held until reset)
//   state              : current state encoding, for debug
// -----------------------------------------------------------------------------
module multicycle_control_fsm
    import control_pkg::*;
#(
    parameter int MEM_LATENCY   = 1,
    parameter bit USE_MEM_READY = 1'b0
) (
    input  logic       clk,
    input  logic       rstN,
    input  logic [6:0] opcode,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       irWrite,
    output logic       regWrite,
    output logic       memRead,
    output logic       memWrite,
    output logic       memGetData,
    output logic [1:0] regWriteDataSelect,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       illegal,
    output logic       halted,
    output logic [3:0] state
);

    state_t currentState;
    state_t nextState;
    logic   inMemState;
    logic   memDone;

    assign inMemState = (currentState == FETCH)    ||
                        (currentState == LOAD_MEM) ||
                        (currentState == STORE_MEM);

    mem_wait_counter #(
        .MEM_LATENCY  (MEM_LATENCY),
        .USE_MEM_READY(USE_MEM_READY)
    ) memWait (
        .clk       (clk),
        .rstN      (rstN),
        .inMemState(inMemState),
        .memReady  (memReady),
        .memDone   (memDone)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            currentState <= RESET;
        end else begin
            currentState <= nextState;
        end
    end

    assign state = currentState;

    always_comb begin
        // NOTE: every output and nextState gets a default before the case so
        // no path through the decode can leave a latch behind.
        nextState          = currentState;
        pcWrite            = 1'b0;
        pcWriteCond        = 1'b0;
        irWrite            = 1'b0;
        regWrite           = 1'b0;
        memRead            = 1'b0;
        memWrite           = 1'b0;
        memGetData         = 1'b0;
        regWriteDataSelect = WBSEL_ALUOUT;
        aluSrcA            = SRCA_PC;
        aluSrcB            = SRCB_REGB;
        aluOp              = ALUOP_ADD;
        pcSrc              = PCSRC_ALU;
        illegal            = 1'b0;
        halted             = 1'b0;

        case (currentState)
            RESET: nextState = FETCH;

            FETCH: begin
                // ALU computes PC + 4 every fetch cycle; it is only committed
                // together with the instruction word when the fetch completes.
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                if (memDone) begin
                    irWrite   = 1'b1;
                    pcWrite   = 1'b1;
                    nextState = DECODE;
                end
            end

            DECODE: begin
                // Speculatively form oldPC + imm: branch/JAL target, AUIPC result.
                aluSrcA = SRCA_OLDPC;
                aluSrcB = SRCB_IMM;
                case (opcode)
                    OPC_OP:               nextState = EXEC_R;
                    OPC_OP_IMM:           nextState = EXEC_I;
                    OPC_LOAD, OPC_STORE:  nextState = MEM_ADDR;
                    OPC_BRANCH:           nextState = BRANCH;
                    OPC_JAL:              nextState = JAL;
                    OPC_JALR:             nextState = JALR;
                    OPC_LUI:              nextState = LUI;
                    OPC_AUIPC:            nextState = ALU_WB;
`ifdef MULTICYCLE_CONTROL_SYSTEM_EN
                    OPC_SYSTEM:           nextState = HALT;
`else
                    OPC_SYSTEM:           nextState = TRAP;
`endif
                    default:              nextState = TRAP;
                endcase
            end

            EXEC_R: begin
                aluSrcA   = SRCA_REGA;
                aluSrcB   = SRCB_REGB;
                aluOp     = ALUOP_FUNCT;
                nextState = ALU_WB;
            end

            EXEC_I: begin
                aluSrcA   = SRCA_REGA;
                aluSrcB   = SRCB_IMM;
                aluOp     = ALUOP_FUNCT;
                nextState = ALU_WB;
            end

            LUI: begin
                aluSrcA   = SRCA_ZERO;
                aluSrcB   = SRCB_IMM;
                nextState = ALU_WB;
            end

            ALU_WB: begin
                regWrite           = 1'b1;
                regWriteDataSelect = WBSEL_ALUOUT;
                nextState          = FETCH;
            end

            BRANCH: begin
                // ALU compares regA/regB; ALUOut still holds the DECODE target.
                aluSrcA     = SRCA_REGA;
                aluOp       = ALUOP_BRANCH;
                pcWriteCond = 1'b1;
                pcSrc       = PCSRC_ALUOUT;
                nextState   = FETCH;
            end

            JAL: begin
                pcWrite            = 1'b1;
                pcSrc              = PCSRC_ALUOUT;
                regWrite           = 1'b1;
                regWriteDataSelect = WBSEL_PC;
                nextState          = FETCH;
            end

            JALR: begin
                aluSrcA            = SRCA_REGA;
                aluSrcB            = SRCB_IMM;
                pcSrc              = PCSRC_ALU_LSB0;
                pcWrite            = 1'b1;
                regWrite           = 1'b1;
                regWriteDataSelect = WBSEL_PC;
                nextState          = FETCH;
            end

            MEM_ADDR: begin
                aluSrcA   = SRCA_REGA;
                aluSrcB   = SRCB_IMM;
                nextState = (opcode == OPC_LOAD) ? LOAD_MEM : STORE_MEM;
            end

            LOAD_MEM: begin
                memRead    = 1'b1;
                memGetData = 1'b1;
                if (memDone) nextState = LOAD_WB;
            end

            LOAD_WB: begin
                regWrite           = 1'b1;
                regWriteDataSelect = WBSEL_MDR;
                nextState          = FETCH;
            end

            STORE_MEM: begin
                memWrite   = 1'b1;
                memGetData = 1'b1;
                if (memDone) nextState = FETCH;
            end

            TRAP: illegal = 1'b1;

`ifdef MULTICYCLE_CONTROL_SYSTEM_EN
            HALT: halted = 1'b1;
`endif

            // Unreachable encodings (HALT when SYSTEM support is off) are
            // treated as an illegal condition rather than silently restarting.
            default: nextState = TRAP;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Three instances share clock, reset and memReady:
//   dut 0 : MEM_LATENCY=1, fixed latency
//   dut 1 : MEM_LATENCY=3, fixed latency
//   dut 2 : memReady handshake
// Each instance runs its own random instruction stream. The reference model
// turns an opcode into the list of steps the instruction must take (expected
// output word per step, memory steps stretch until the access completes).
// Instruction latency and strobe pulse counts are additionally checked
// against hand-computed figures.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       memReady = 1'b0;
    logic [6:0] opc [3];

    logic       pcWrite [3];
    logic       pcWriteCond [3];
    logic       irWrite [3];
    logic       regWrite [3];
    logic       memRead [3];
    logic       memWrite [3];
    logic       memGetData [3];
    logic [1:0] regWriteDataSelect [3];
    logic [1:0] aluSrcA [3];
    logic [1:0] aluSrcB [3];
    logic [1:0] aluOp [3];
    logic [1:0] pcSrc [3];
    logic       illegal [3];
    logic       halted [3];
    logic [3:0] st [3];

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_LATENCY(1), .USE_MEM_READY(1'b0)) dut0 (
        .clk(clk), .rstN(rstN), .opcode(opc[0]), .memReady(memReady),
        .pcWrite(pcWrite[0]), .pcWriteCond(pcWriteCond[0]), .irWrite(irWrite[0]),
        .regWrite(regWrite[0]), .memRead(memRead[0]), .memWrite(memWrite[0]),
        .memGetData(memGetData[0]), .regWriteDataSelect(regWriteDataSelect[0]),
        .aluSrcA(aluSrcA[0]), .aluSrcB(aluSrcB[0]), .aluOp(aluOp[0]), .pcSrc(pcSrc[0]),
        .illegal(illegal[0]), .halted(halted[0]), .state(st[0]));

    multicycle_control_fsm #(.MEM_LATENCY(3), .USE_MEM_READY(1'b0)) dut1 (
        .clk(clk), .rstN(rstN), .opcode(opc[1]), .memReady(memReady),
        .pcWrite(pcWrite[1]), .pcWriteCond(pcWriteCond[1]), .irWrite(irWrite[1]),
        .regWrite(regWrite[1]), .memRead(memRead[1]), .memWrite(memWrite[1]),
        .memGetData(memGetData[1]), .regWriteDataSelect(regWriteDataSelect[1]),
        .aluSrcA(aluSrcA[1]), .aluSrcB(aluSrcB[1]), .aluOp(aluOp[1]), .pcSrc(pcSrc[1]),
        .illegal(illegal[1]), .halted(halted[1]), .state(st[1]));

    multicycle_control_fsm #(.MEM_LATENCY(1), .USE_MEM_READY(1'b1)) dut2 (
        .clk(clk), .rstN(rstN), .opcode(opc[2]), .memReady(memReady),
        .pcWrite(pcWrite[2]), .pcWriteCond(pcWriteCond[2]), .irWrite(irWrite[2]),
        .regWrite(regWrite[2]), .memRead(memRead[2]), .memWrite(memWrite[2]),
        .memGetData(memGetData[2]), .regWriteDataSelect(regWriteDataSelect[2]),
        .aluSrcA(aluSrcA[2]), .aluSrcB(aluSrcB[2]), .aluOp(aluOp[2]), .pcSrc(pcSrc[2]),
        .illegal(illegal[2]), .halted(halted[2]), .state(st[2]));

    // ---------------- checking bookkeeping ----------------
    int checks = 0;
    int failures = 0;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output word: {state[22:19], pcWrite, pcWriteCond, irWrite, regWrite,
    // memRead, memWrite, memGetData, wbSel[11:10], srcA[9:8], srcB[7:6],
    // aluOp[5:4], pcSrc[3:2], illegal, halted}
    function automatic logic [22:0] obs(input int d);
        return {st[d], pcWrite[d], pcWriteCond[d], irWrite[d], regWrite[d],
                memRead[d], memWrite[d], memGetData[d], regWriteDataSelect[d],
                aluSrcA[d], aluSrcB[d], aluOp[d], pcSrc[d], illegal[d], halted[d]};
    endfunction

    // strobes = {pcWrite, pcWriteCond, irWrite, regWrite, memRead, memWrite, memGetData}
    function automatic logic [22:0] mk(input logic [3:0] s, input logic [6:0] strobes,
                                       input logic [1:0] wb, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] op,
                                       input logic [1:0] ps, input logic ill,
                                       input logic hlt);
        return {s, strobes, wb, sa, sb, op, ps, ill, hlt};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [22:0] out;
        bit          isMem;
        bit          isFetch;
        bit          terminal;
    } step_t;

    step_t      plan [3][8];
    int         planLen [3];
    int         planIdx [3];
    int         memCnt [3];
    logic [6:0] forceOpc [3];
    bit         forceValid [3];

    // latency-pin bookkeeping, observed from the DUT outputs
    bit         inflight [3];
    logic [6:0] curOpc [3];
    int         cyc [3];
    int         irCnt [3];
    int         rwCnt [3];
    logic [3:0] prevSt [3];

    function automatic int latOf(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    function automatic int expLatency(input logic [6:0] o, input int l);
        case (o)
            7'b0000011:                         return 5 + 2 * (l - 1);
            7'b0100011:                         return 4 + 2 * (l - 1);
            7'b0110011, 7'b0010011, 7'b0110111: return 4 + (l - 1);
            default:                            return 3 + (l - 1);
        endcase
    endfunction

    function automatic int expRegWrites(input logic [6:0] o);
        return (o == 7'b1100011 || o == 7'b0100011) ? 0 : 1;
    endfunction

    function automatic logic [6:0] randomOpcode();
        logic [6:0] legal [9];
        int r;
        legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        r = $urandom_range(0, 199);
        if (r == 0) return 7'b1110011;
        if (r == 1) return 7'b1111111;
        if (r == 2) return 7'b0000000;
        return legal[$urandom_range(0, 8)];
    endfunction

    task automatic addStep(input int d, input logic [22:0] o, input bit m,
                           input bit f, input bit t);
        plan[d][planLen[d]] = '{out: o, isMem: m, isFetch: f, terminal: t};
        planLen[d]++;
    endtask

    task automatic loadInstr(input int d);
        logic [6:0] o;
        logic [22:0] wb;
        if (forceValid[d]) begin
            o = forceOpc[d];
            forceValid[d] = 1'b0;
        end else begin
            o = randomOpcode();
        end
        opc[d] = o;
        planLen[d] = 0;
        planIdx[d] = 0;
        memCnt[d] = 0;
        wb = mk(4'd6, 7'b0001000, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addStep(d, mk(4'd1, 7'b0000100, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b0, 1'b0), 1, 1, 0);
        addStep(d, mk(4'd2, 7'b0000000, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0), 0, 0, 0);
        case (o)
            7'b0110011: begin
                addStep(d, mk(4'd3, 7'b0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0), 0, 0, 0);
                addStep(d, wb, 0, 0, 0);
            end
            7'b0010011: begin
                addStep(d, mk(4'd4, 7'b0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd0, 1'b0, 1'b0), 0, 0, 0);
                addStep(d, wb, 0, 0, 0);
            end
            7'b0110111: begin
                addStep(d, mk(4'd5, 7'b0, 2'd0, 2'd3, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0), 0, 0, 0);
                addStep(d, wb, 0, 0, 0);
            end
            7'b0010111: addStep(d, wb, 0, 0, 0);
            7'b0000011: begin
                addStep(d, mk(4'd10, 7'b0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0), 0, 0, 0);
                addStep(d, mk(4'd11, 7'b0000101, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), 1, 0, 0);
                addStep(d, mk(4'd12, 7'b0001000, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), 0, 0, 0);
            end
            7'b0100011: begin
                addStep(d, mk(4'd10, 7'b0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 1'b0, 1'b0), 0, 0, 0);
                addStep(d, mk(4'd13, 7'b0000011, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0), 1, 0, 0);
            end
            7'b1100011:
                addStep(d, mk(4'd7, 7'b0100000, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0), 0, 0, 0);
            7'b1101111:
                addStep(d, mk(4'd8, 7'b1001000, 2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0), 0, 0, 0);
            7'b1100111:
                addStep(d, mk(4'd9, 7'b1001000, 2'd2, 2'd1, 2'd2, 2'd0, 2'd2, 1'b0, 1'b0), 0, 0, 0);
`ifdef MULTICYCLE_CONTROL_SYSTEM_EN
            7'b1110011:
                addStep(d, mk(4'd15, 7'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1), 0, 0, 1);
`endif
            default:
                addStep(d, mk(4'd14, 7'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0), 0, 0, 1);
        endcase
    endtask

    task automatic resetModels();
        for (int d = 0; d < 3; d++) begin
            plan[d][0] = '{out: 23'd0, isMem: 1'b0, isFetch: 1'b0, terminal: 1'b0};
            planLen[d] = 1;
            planIdx[d] = 0;
            memCnt[d] = 0;
            inflight[d] = 1'b0;
            prevSt[d] = 4'd0;
            cyc[d] = 0;
            irCnt[d] = 0;
            rwCnt[d] = 0;
        end
    endtask

    task automatic compareAdvance(input int d);
        step_t s;
        bit done;
        logic [22:0] exp;
        logic [22:0] act;
        s = plan[d][planIdx[d]];
        done = 1'b0;
        if (s.isMem) done = (d == 2) ? memReady : (memCnt[d] + 1 == latOf(d));
        exp = s.out;
        if (s.isFetch && done) begin
            exp[18] = 1'b1;
            exp[16] = 1'b1;
        end
        act = obs(d);
        check(act == exp, $sformatf("dut%0d_outputs", d), 32'(act), 32'(exp));

        // Instruction-level pins, taken at each entry into FETCH.
        if (act[22:19] == 4'd1 && prevSt[d] != 4'd1) begin
            if (inflight[d]) begin
                if (d != 2)
                    check(cyc[d] == expLatency(curOpc[d], latOf(d)),
                          $sformatf("dut%0d_latency_op%07b", d, curOpc[d]),
                          32'(cyc[d]), 32'(expLatency(curOpc[d], latOf(d))));
                check(irCnt[d] == 1, $sformatf("dut%0d_irWrite_pulses", d),
                      32'(irCnt[d]), 32'd1);
                check(rwCnt[d] == expRegWrites(curOpc[d]),
                      $sformatf("dut%0d_regWrite_pulses_op%07b", d, curOpc[d]),
                      32'(rwCnt[d]), 32'(expRegWrites(curOpc[d])));
            end
            inflight[d] = 1'b1;
            curOpc[d] = opc[d];
            cyc[d] = 0;
            irCnt[d] = 0;
            rwCnt[d] = 0;
        end
        cyc[d]++;
        irCnt[d] += int'(act[16]);
        rwCnt[d] += int'(act[15]);
        prevSt[d] = act[22:19];

        if (s.terminal) begin
            // stays put until reset
        end else if (s.isMem && !done) begin
            memCnt[d]++;
        end else begin
            memCnt[d] = 0;
            planIdx[d]++;
            if (planIdx[d] == planLen[d]) loadInstr(d);
        end
    endtask

    int readyBias = 7;

    task automatic runCycle();
        @(posedge clk);
        #1;
        memReady = ($urandom_range(0, 9) < readyBias);
        @(negedge clk);
        for (int d = 0; d < 3; d++) compareAdvance(d);
    endtask

    task automatic checkAllZero(input string tag);
        for (int d = 0; d < 3; d++)
            check(obs(d) == 23'd0, $sformatf("dut%0d_%s", d, tag), 32'(obs(d)), 32'd0);
    endtask

    // Assert reset mid-cycle (instances are mid-instruction), check the
    // asynchronous clear, then release just after an edge so the RESET cycle
    // is observed before FETCH.
    task automatic pulseReset();
        @(posedge clk);
        #3 rstN = 1'b0;
        #1 checkAllZero("reset_async");
        @(negedge clk);
        checkAllZero("reset_hold");
        @(posedge clk);
        #1 rstN = 1'b1;
        resetModels();
        @(negedge clk);
        for (int d = 0; d < 3; d++) compareAdvance(d);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            opc[d] = 7'd0;
            forceValid[d] = 1'b0;
            forceOpc[d] = 7'd0;
        end
        resetModels();

        // Directed first episode: R-type at latency 1, load at latency 3,
        // store through the handshake with memReady mostly low.
        forceOpc[0] = 7'b0110011; forceValid[0] = 1'b1;
        forceOpc[1] = 7'b0000011; forceValid[1] = 1'b1;
        forceOpc[2] = 7'b0100011; forceValid[2] = 1'b1;
        readyBias = 3;
        repeat (2) @(posedge clk);
        pulseReset();
        repeat (40) runCycle();

        for (int ep = 0; ep < 40; ep++) begin
            readyBias = $urandom_range(2, 10);
            pulseReset();
            repeat ($urandom_range(20, 80)) runCycle();
        end

        // Final episode: illegal opcode, SYSTEM, and an R-type; the terminal
        // states must hold for well over 20 cycles.
        forceOpc[0] = 7'b1111111; forceValid[0] = 1'b1;
        forceOpc[1] = 7'b1110011; forceValid[1] = 1'b1;
        forceOpc[2] = 7'b0110011; forceValid[2] = 1'b1;
        readyBias = 10;
        pulseReset();
        repeat (30) runCycle();
        check(illegal[0] == 1'b1, "dut0_illegal_sticky", 32'(illegal[0]), 32'd1);
`ifdef MULTICYCLE_CONTROL_SYSTEM_EN
        check(halted[1] == 1'b1, "dut1_system_halted", 32'(halted[1]), 32'd1);
`else
        check(illegal[1] == 1'b1, "dut1_system_illegal", 32'(illegal[1]), 32'd1);
`endif
        pulseReset();
        repeat (5) runCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
